// File: rtl/bresenham_line_gen.sv
// Bresenham line rasteriser: one endpoint pair in, one pixel per pix_valid/pix_ready beat out.
// First pixel two cycles after accept; pixel outputs hold under back-pressure; abort/last pulse done.
module bresenham_line_gen #(
    parameter int WIDTH = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic signed [WIDTH-1:0] x0,
    input  logic signed [WIDTH-1:0] y0,
    input  logic signed [WIDTH-1:0] x1,
    input  logic signed [WIDTH-1:0] y1,
    input  logic                    abort,
    output logic                    pix_valid,
    input  logic                    pix_ready,
    output logic [WIDTH-1:0]        pix_x,
    output logic [WIDTH-1:0]        pix_y,
    output logic                    pix_last,
    output logic                    done
);
    localparam int DW = WIDTH + 1;
    localparam int EW = WIDTH + 2;

    typedef enum logic [1:0] {IDLE, SETUP, DRAW} state_t;

    state_t                 state_q, state_d;
    logic signed [WIDTH-1:0] ex0_q, ey0_q, ex1_q, ey1_q;
    logic signed [WIDTH-1:0] ex0_d, ey0_d, ex1_d, ey1_d;
    logic                   steep_q, steep_d, yneg_q, yneg_d, done_q, done_d;
    logic [DW-1:0]          dx_q, dx_d, dy_q, dy_d, rem_q, rem_d;
    logic signed [EW-1:0]   err_q, err_d;
    logic [WIDTH-1:0]       x_q, x_d, y_q, y_d;

    // Setup datapath, evaluated from the registered endpoints
    logic signed [DW-1:0]    ddx, ddy, adx, ady, dbs, dx_s, dy_s;
    logic signed [WIDTH-1:0] a0, b0, a1, b1, sa0, sb0, sa1, sb1;
    logic                    steep_s, swap_s;
    logic signed [EW-1:0]    e_s;

    always_comb begin
        ddx     = {ex1_q[WIDTH-1], ex1_q} - {ex0_q[WIDTH-1], ex0_q};
        ddy     = {ey1_q[WIDTH-1], ey1_q} - {ey0_q[WIDTH-1], ey0_q};
        adx     = (ddx < 0) ? -ddx : ddx;
        ady     = (ddy < 0) ? -ddy : ddy;
        steep_s = ady > adx;
        a0      = steep_s ? ey0_q : ex0_q;
        b0      = steep_s ? ex0_q : ey0_q;
        a1      = steep_s ? ey1_q : ex1_q;
        b1      = steep_s ? ex1_q : ey1_q;
        swap_s  = a0 > a1;
        sa0     = swap_s ? a1 : a0;
        sb0     = swap_s ? b1 : b0;
        sa1     = swap_s ? a0 : a1;
        sb1     = swap_s ? b0 : b1;
        dx_s    = {sa1[WIDTH-1], sa1} - {sa0[WIDTH-1], sa0};
        dbs     = {sb1[WIDTH-1], sb1} - {sb0[WIDTH-1], sb0};
        dy_s    = (dbs < 0) ? -dbs : dbs;
        e_s     = err_q - $signed({1'b0, dy_q});
    end

    always_comb begin
        state_d = state_q;
        ex0_d   = ex0_q;
        ey0_d   = ey0_q;
        ex1_d   = ex1_q;
        ey1_d   = ey1_q;
        steep_d = steep_q;
        yneg_d  = yneg_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        rem_d   = rem_q;
        err_d   = err_q;
        x_d     = x_q;
        y_d     = y_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    ex0_d   = x0;
                    ey0_d   = y0;
                    ex1_d   = x1;
                    ey1_d   = y1;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (abort) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    steep_d = steep_s;
                    yneg_d  = !(sb0 < sb1);
                    dx_d    = dx_s;
                    dy_d    = dy_s;
                    rem_d   = dx_s;
                    err_d   = $signed({2'b00, dx_s[DW-1:1]});
                    x_d     = sa0;
                    y_d     = sb0;
                    state_d = DRAW;
                end
            end
            DRAW: begin
                // A last-pixel handshake wins over a coincident abort: the pixel is delivered
                if (pix_ready && rem_q == '0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else if (abort) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else if (pix_ready) begin
                    x_d   = x_q + WIDTH'(1);
                    rem_d = rem_q - DW'(1);
                    if (e_s < 0) begin
                        y_d   = yneg_q ? y_q - WIDTH'(1) : y_q + WIDTH'(1);
                        err_d = e_s + $signed({1'b0, dx_q});
                    end else begin
                        err_d = e_s;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ex0_q   <= '0;
            ey0_q   <= '0;
            ex1_q   <= '0;
            ey1_q   <= '0;
            steep_q <= 1'b0;
            yneg_q  <= 1'b0;
            dx_q    <= '0;
            dy_q    <= '0;
            rem_q   <= '0;
            err_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ex0_q   <= ex0_d;
            ey0_q   <= ey0_d;
            ex1_q   <= ex1_d;
            ey1_q   <= ey1_d;
            steep_q <= steep_d;
            yneg_q  <= yneg_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            rem_q   <= rem_d;
            err_q   <= err_d;
            x_q     <= x_d;
            y_q     <= y_d;
            done_q  <= done_d;
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign pix_valid = (state_q == DRAW);
    assign pix_last  = (state_q == DRAW) && (rem_q == '0);
    assign pix_x     = steep_q ? y_q : x_q;
    assign pix_y     = steep_q ? x_q : y_q;
    assign done      = done_q;
endmodule

// File: tb/tb_bresenham_line_gen.sv
// Scoreboard bench for bresenham_line_gen: directed lines, back-pressure, abort and mid-line reset.
module tb_bresenham_line_gen;
    localparam int W = 10;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                cmd_valid = 1'b0;
    logic                cmd_ready;
    logic signed [W-1:0] x0 = '0, y0 = '0, x1 = '0, y1 = '0;
    logic                abort = 1'b0;
    logic                pix_valid;
    logic                pix_ready = 1'b1;
    logic [W-1:0]        pix_x, pix_y;
    logic                pix_last;
    logic                done;

    typedef struct {
        logic signed [W-1:0] x;
        logic signed [W-1:0] y;
        logic                last;
    } pix_t;

    pix_t sb_q[$];
    int   errors  = 0;
    int   checks  = 0;
    int   pop_cnt = 0;

    bresenham_line_gen #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .x0(x0), .y0(y0), .x1(x1), .y1(y1), .abort(abort),
        .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_x(pix_x), .pix_y(pix_y), .pix_last(pix_last), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input int x, input int y, input logic last);
        pix_t p;
        p.x = W'(x);
        p.y = W'(y);
        p.last = last;
        sb_q.push_back(p);
    endtask

    // Monitor: every pixel handshake is compared with the scoreboard head
    always @(negedge clk) begin
        if (!rst && pix_valid && pix_ready) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL pix_unexpected: got (%0d,%0d) expected no pixel",
                         $signed(pix_x), $signed(pix_y));
            end else begin
                pix_t e;
                e = sb_q.pop_front();
                if ($signed(pix_x) != e.x || $signed(pix_y) != e.y || pix_last != e.last) begin
                    errors++;
                    $display("FAIL pix: got (%0d,%0d,last=%0b) expected (%0d,%0d,last=%0b)",
                             $signed(pix_x), $signed(pix_y), pix_last, e.x, e.y, e.last);
                end
            end
            pop_cnt++;
        end
    end

    task automatic issue(input int ax0, input int ay0, input int ax1, input int ay1);
        pop_cnt   = 0;
        x0        = W'(ax0);
        y0        = W'(ay0);
        x1        = W'(ax1);
        y1        = W'(ay1);
        cmd_valid = 1'b1;
        chk("cmd_ready_before_accept", int'(cmd_ready), 1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    // Runs a whole line; stall_at = pixels delivered before pix_ready drops for stall_len cycles
    task automatic run_line(input int ax0, input int ay0, input int ax1, input int ay1,
                            input int exp_cycles, input int stall_at, input int stall_len);
        int cyc, first, stall_left;
        bit got_done;
        issue(ax0, ay0, ax1, ay1);
        chk("setup_pix_valid", int'(pix_valid), 0);
        chk("setup_cmd_ready", int'(cmd_ready), 0);
        cyc = 1;
        first = 0;
        got_done = 1'b0;
        stall_left = stall_len;
        while (!got_done && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
            if (pix_valid && first == 0) first = cyc;
            if (pix_valid && pop_cnt == stall_at && stall_left > 0) begin
                pix_ready = 1'b0;
                stall_left--;
                if (sb_q.size() > 0) begin
                    chk("hold_x", int'($signed(pix_x)), int'(sb_q[0].x));
                    chk("hold_y", int'($signed(pix_y)), int'(sb_q[0].y));
                end
            end else begin
                pix_ready = 1'b1;
            end
            if (done) got_done = 1'b1;
        end
        chk("done_seen", int'(got_done), 1);
        chk("line_cycles", cyc, exp_cycles);
        chk("first_pixel_latency", first, 2);
        chk("idle_after_done", int'(cmd_ready), 1);
        chk("scoreboard_drained", sb_q.size(), 0);
        @(posedge clk);
        #1;
        chk("done_one_cycle", int'(done), 0);
    endtask

    initial begin
        int  i;
        bit  found;
        int  done_cnt;
        #2;
        chk("rst_cmd_ready", int'(cmd_ready), 1);
        chk("rst_pix_valid", int'(pix_valid), 0);
        chk("rst_pix_last", int'(pix_last), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_pix_x", int'(pix_x), 0);
        chk("rst_pix_y", int'(pix_y), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Horizontal
        push(0, 0, 0); push(1, 0, 0); push(2, 0, 0); push(3, 0, 0); push(4, 0, 1);
        run_line(0, 0, 4, 0, 7, -1, 0);
        // Steep
        push(0, 0, 0); push(0, 1, 0); push(1, 2, 0); push(1, 3, 0); push(2, 4, 0); push(2, 5, 1);
        run_line(0, 0, 2, 5, 8, -1, 0);
        // Reversed, negative ystep
        push(0, 2, 0); push(1, 2, 0); push(2, 1, 0); push(3, 1, 0); push(4, 0, 1);
        run_line(4, 0, 0, 2, 7, -1, 0);
        // Negative coordinates
        push(-3, -1, 0); push(-2, -1, 0); push(-1, -1, 0); push(0, -1, 1);
        run_line(-3, -1, 0, -1, 6, -1, 0);
        // Degenerate
        push(7, 7, 1);
        run_line(7, 7, 7, 7, 3, -1, 0);
        // Steep with 3-cycle stall on the 3rd pixel
        push(0, 0, 0); push(0, 1, 0); push(1, 2, 0); push(1, 3, 0); push(2, 4, 0); push(2, 5, 1);
        run_line(0, 0, 2, 5, 11, 2, 3);

        // Abort on the 4th pixel of (0,0)->(9,0)
        push(0, 0, 0); push(1, 0, 0); push(2, 0, 0);
        issue(0, 0, 9, 0);
        found = 1'b0;
        for (i = 0; i < 50 && !found; i++) begin
            @(posedge clk);
            #1;
            if (pix_valid && pop_cnt == 3) begin
                found = 1'b1;
                pix_ready = 1'b0;
                abort = 1'b1;
            end
        end
        chk("abort_reached_4th", int'(found), 1);
        @(posedge clk);
        #1;
        abort = 1'b0;
        pix_ready = 1'b1;
        chk("abort_pix_valid", int'(pix_valid), 0);
        chk("abort_done", int'(done), 1);
        chk("abort_cmd_ready", int'(cmd_ready), 1);
        @(posedge clk);
        #1;
        chk("abort_done_once", int'(done), 0);
        chk("abort_scoreboard", sb_q.size(), 0);

        // Reset on the 2nd pixel
        push(0, 0, 0);
        issue(0, 0, 9, 0);
        found = 1'b0;
        for (i = 0; i < 50 && !found; i++) begin
            @(posedge clk);
            #1;
            if (pix_valid && pop_cnt == 1) found = 1'b1;
        end
        chk("reset_reached_2nd", int'(found), 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_pix_valid", int'(pix_valid), 0);
        chk("mid_rst_pix_x", int'(pix_x), 0);
        chk("mid_rst_pix_y", int'(pix_y), 0);
        chk("mid_rst_pix_last", int'(pix_last), 0);
        chk("mid_rst_done", int'(done), 0);
        chk("mid_rst_cmd_ready", int'(cmd_ready), 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        done_cnt = 0;
        for (i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (done || pix_valid) done_cnt++;
        end
        chk("no_done_after_rst", done_cnt, 0);
        chk("rst_scoreboard", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/bresenham_line_gen.md
# bresenham_line_gen

Sequential, parametrised Bresenham line rasteriser. It accepts one line command (two endpoints) through a valid/ready handshake and internally derives the steep flag, endpoint ordering, deltas and ystep. It then emits one pixel coordinate per accepted output beat, with back-pressure, a last-pixel marker and abort. It sits between the primitive setup stage and the framebuffer write stage of the GPU pipeline.

## Interface
- WIDTH, 10: coordinate width; all coordinates are signed two's complement.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- cmd_valid  in  1  line command present.
- cmd_ready  out  1  block can accept a command; high exactly in IDLE.
- x0, y0, x1, y1  in  WIDTH each  endpoints; sampled on cmd_valid & cmd_ready.
- abort  in  1  synchronous cancel of the line in progress.
- pix_valid  out  1  pix_x/pix_y hold a valid pixel.
- pix_ready  in  1  downstream accepts the pixel.
- pix_x, pix_y  out  WIDTH each  pixel coordinate, already un-swapped for steep lines.
- pix_last  out  1  qualifies the final pixel of the line.
- done  out  1  one-cycle pulse after the last pixel handshake or an abort.

## Operation
- States:
  - IDLE: cmd_ready=1. Command handshake registers the endpoints and moves to SETUP.
  - SETUP: one cycle, then DRAW. In this cycle the block computes and registers:
    - steep = |y1−y0| > |x1−x0|; if steep, swap x↔y of both endpoints.
    - If x0 > x1 (signed), swap the endpoints.
    - deltax = x1−x0 (≥0).
    - deltay = |y1−y0|.
    - ystep = +1 if y0 < y1, else −1.
    - error = deltax >>> 1 (arithmetic).
    - x = x0, y = y0.
    - remaining = deltax.
  - DRAW: pix_valid=1.
    - Output is (y,x) if steep, else (x,y).
    - pix_last = (remaining==0).
    - On pix_valid & pix_ready with remaining≠0:
      - x += 1, remaining −= 1, e = error − deltay.
      - If e < 0: y += ystep, error = e + deltax; else error = e.
    - On the handshake with pix_last: go to IDLE and pulse done.
- Width rules:
  - Differences are computed sign-extended to WIDTH+1 bits, so there is no overflow for any signed WIDTH inputs.
  - error is WIDTH+2 bits signed.
  - remaining is WIDTH+1 bits unsigned.
  - pix_x/pix_y are the low WIDTH bits and always lie between the endpoints.
- Pixels are emitted in increasing major-axis order, not command order. The count per line is deltax+1, both endpoints inclusive.
- Degenerate line (x0==x1, y0==y1): exactly one pixel, with pix_last=1.
- abort:
  - Honoured in SETUP or DRAW.
  - Next state is IDLE and pix_valid drops the next cycle.
  - done pulses once; any pixel not yet handshaken is discarded.
  - In IDLE, abort is ignored.
- abort and the last-pixel handshake in the same cycle: the pixel counts as delivered, and done pulses once.

## Timing
- Reset values (asynchronous, held while rst=1):
  - state = IDLE, so cmd_ready=1.
  - pix_valid = 0, pix_last = 0, done = 0.
  - pix_x = 0, pix_y = 0.
  - All internal registers = 0.
- Latency: a command accepted at edge N gives SETUP in cycle N+1 and the first pix_valid in cycle N+2.
- Throughput: one pixel per cycle while pix_ready=1.
- After the last handshake at edge M: cycle M+1 has state IDLE, done=1 and cmd_ready=1. The next command can be accepted at edge M+1.
- Minimum spacing between commands is therefore deltax+3 cycles.
- Back-pressure: while pix_valid=1 and pix_ready=0, pix_x/pix_y/pix_last are held stable. pix_valid never drops without a handshake, abort or reset.
- rst asserted mid-line: outputs go to their reset values immediately and the line is lost. No done pulse is generated.

## Test plan
- Horizontal line (0,0)→(4,0), pix_ready=1:
  - Pixels (0,0),(1,0),(2,0),(3,0),(4,0) on consecutive cycles, starting 2 cycles after accept.
  - pix_last on the 5th pixel; done the cycle after.
- Steep line (0,0)→(2,5):
  - Pixels (0,0),(0,1),(1,2),(1,3),(2,4),(2,5); pix_last on (2,5).
- Reversed, negative-ystep line (4,0)→(0,2):
  - Pixels (0,2),(1,2),(2,1),(3,1),(4,0).
- Negative coordinates and a single pixel:
  - (−3,−1)→(0,−1) gives (−3,−1),(−2,−1),(−1,−1),(0,−1) as signed values.
  - (7,7)→(7,7) gives one pixel (7,7) with pix_last=1.
- Back-pressure: on the steep line, drop pix_ready for 3 cycles at the 3rd pixel.
  - (1,2) is held for those 3 cycles.
  - The sequence is otherwise unchanged, and total duration grows by 3.
- Abort, then reset, on (0,0)→(9,0):
  - Abort at the 4th pixel: pix_valid is 0 the next cycle, done pulses once, cmd_ready=1.
  - Reissue the line and assert rst at the 2nd pixel: all outputs go to 0 immediately, with no done pulse.
